// File: rtl/clock_meter.sv
// Measures period and high time of a slow asynchronous signal in clk cycles,
// averaged over 2^AVG_LOG2 periods, with single-shot and continuous modes.
module clock_meter #(
  parameter int WIDTH    = 32,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             valid,
  output logic             timeout,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARM     = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;

  localparam int             NW        = AVG_LOG2 + 1;
  localparam logic [NW-1:0]  NPER_LAST = NW'((1 << AVG_LOG2) - 1);
  localparam logic [WIDTH-1:0] GAP_LAST = WIDTH'(TIMEOUT - 1);

  // The accumulated count over a full window must never wrap.
  if ((WIDTH < 64) && ((64'(TIMEOUT) << AVG_LOG2) >= (64'd1 << WIDTH))) begin : g_bad_params
    $error("clock_meter: TIMEOUT * 2^AVG_LOG2 must be below 2^WIDTH");
  end

  logic             s1, s2, prev;
  logic [1:0]       state;
  logic             seen_low;
  logic [WIDTH-1:0] cnt, high_acc, gap;
  logic [NW-1:0]    nper;
  logic             rise;

  assign rise      = s2 & ~prev;
  // valid and timeout are single-cycle pulses with no back-pressure; period and
  // high_time are stable from the valid cycle until the next valid.
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      prev      <= 1'b0;
      state     <= S_IDLE;
      seen_low  <= 1'b0;
      cnt       <= '0;
      high_acc  <= '0;
      gap       <= '0;
      nper      <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      period    <= '0;
      high_time <= '0;
    end else begin
      s1      <= sig_in;
      s2      <= s1;
      prev    <= s2;
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          gap      <= '0;
          seen_low <= 1'b0;
          cnt      <= '0;
          high_acc <= '0;
          nper     <= '0;
          if (start) state <= S_ARM;
        end
        S_ARM: begin
          if (!s2) seen_low <= 1'b1;
          // A rise only arms once a genuine low level has been observed.
          if (rise && seen_low) begin
            cnt      <= WIDTH'(1);
            high_acc <= WIDTH'(1);
            nper     <= '0;
            gap      <= '0;
            state    <= S_MEASURE;
          end else if (rise) begin
            gap <= '0;
          end else if (gap == GAP_LAST) begin
            timeout <= 1'b1;
            state   <= S_IDLE;
          end else begin
            gap <= gap + WIDTH'(1);
          end
        end
        S_MEASURE: begin
          if (rise) begin
            if (nper == NPER_LAST) begin
              period    <= cnt >> AVG_LOG2;
              high_time <= high_acc >> AVG_LOG2;
              valid     <= 1'b1;
              // The completing rise doubles as the next arm edge.
              if (cont) begin
                cnt      <= WIDTH'(1);
                high_acc <= WIDTH'(1);
                nper     <= '0;
                gap      <= '0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              nper     <= nper + NW'(1);
              cnt      <= cnt + WIDTH'(1);
              high_acc <= high_acc + WIDTH'(s2);
              gap      <= '0;
            end
          end else if (gap == GAP_LAST) begin
            timeout <= 1'b1;
            state   <= S_IDLE;
          end else begin
            cnt      <= cnt + WIDTH'(1);
            high_acc <= high_acc + WIDTH'(s2);
            gap      <= gap + WIDTH'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/clock_meter.md
# clock_meter

Measures the period and high time of a slow, asynchronous clock-like signal in units of `clk` cycles. It is the receive side of the divided-clock path: `clock_div` and `get_clock` generate a slow enable or clock from `clk`, and `clock_meter` recovers the period of such a signal. Typical uses are self-check of generated clocks and readback of externally supplied reference clocks. Results are averaged over 2^AVG_LOG2 periods and reported with a one-cycle valid pulse.

## Interface
- WIDTH, 32, width of all counters and results
- AVG_LOG2, 2, log2 of the number of periods averaged per measurement
- TIMEOUT, 1000000, maximum `clk` cycles allowed between detected rising edges before the measurement is aborted
- Constraint checked at elaboration: TIMEOUT * 2^AVG_LOG2 < 2^WIDTH
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- sig_in  in  1  asynchronous slow signal to measure
- start  in  1  request one measurement; sampled only in IDLE
- cont  in  1  continuous mode; sampled at each completion
- busy  out  1  high in ARM and MEASURE
- valid  out  1  one-cycle pulse when new results are loaded
- timeout  out  1  one-cycle pulse when a measurement is aborted
- period  out  WIDTH  averaged period in `clk` cycles; holds until the next valid
- high_time  out  WIDTH  averaged high cycles per period; holds until the next valid

## Operation
- Input path:
  - `sig_in` passes through a 2-flop synchronizer (s1, s2) and then a previous-level register `prev`.
  - rise = s2 & ~prev.
  - All three registers clear to 0 on reset.
- States: IDLE, ARM, MEASURE.
- IDLE:
  - start=1 moves to ARM.
  - On entry, clears gap, `seen_low`, cnt, high_acc and nper.
- ARM:
  - `seen_low` is set when s2=0.
  - A rise with `seen_low`=1 is the arm edge: cnt<=1, high_acc<=1, nper<=0, gap<=0, go to MEASURE.
  - A rise with `seen_low`=0 is ignored. This rejects spurious rises after reset or when `sig_in` is already high at start.
- MEASURE, every cycle:
  - cnt<=cnt+1.
  - high_acc<=high_acc+s2.
  - gap<=gap+1, or gap<=0 on a rise.
- MEASURE, on each rise: nper<=nper+1.
- Completion: the rise where nper=2^AVG_LOG2-1.
  - period<=cnt>>AVG_LOG2.
  - high_time<=high_acc>>AVG_LOG2.
  - valid<=1.
  - The shift truncates; no rounding.
  - cont=1: this rise becomes the new arm edge (cnt<=1, high_acc<=1, nper<=0, gap<=0), stay in MEASURE, no dead cycles.
  - cont=0: go to IDLE.
- Timeout: in ARM or MEASURE, if gap=TIMEOUT-1 and there is no rise, pulse timeout, go to IDLE, and leave period and high_time unchanged.
- start while busy is ignored. cont is ignored outside completion.
- Simultaneous rise and gap=TIMEOUT-1: the rise wins and there is no timeout.
- Reset at any point:
  - state goes to IDLE.
  - busy, valid, timeout, period, high_time and all counters go to 0.
  - Any measurement in flight is discarded.

## Timing
- Reset values: all outputs are 0.
- busy rises the cycle after start is accepted in IDLE.
- busy falls in the same cycle valid or timeout is high when returning to IDLE.
- Edge detection latency: a `sig_in` rise before clk edge e0 gives rise=1 in the cycle between e1 and e2.
- That latency is constant, so it cancels in the period and high_time measurements.
- Output latency: valid and the results are visible 3 clk edges after the final `sig_in` rise (e0, e1, register load at e2).
- Results are exact for a `sig_in` period P of at least 4 cycles. Below that, results are undefined.
- Timeout pulse: when no rise arrives, timeout is high TIMEOUT+1 cycles after start acceptance (ARM timeout) or after the last rise (MEASURE timeout).
- Continuous mode: valid pulses every 2^AVG_LOG2 * P cycles.

## Test plan
- Single measurement:
  - Stimulus: AVG_LOG2=2, `sig_in` period 10 cycles at 50% duty, start pulse, cont=0.
  - Required: exactly one valid pulse, period=10, high_time=5.
  - Required: valid occurs 3 edges after the 5th counted rise (the arm rise plus 4 more); busy low in the same cycle.
- Duty cycle and averaging:
  - Stimulus: `sig_in` period 10 with 3 cycles high.
  - Required: high_time=3.
  - Stimulus: alternating periods 9 and 10.
  - Required: period=9, since 38>>2 truncates.
- Stuck input:
  - Stimulus: TIMEOUT=50, `sig_in` held high through start.
  - Required: the held-high level produces no rise.
  - Required: timeout pulses 51 cycles after start acceptance; valid never asserts; period and high_time keep their prior values.
- Continuous mode:
  - Stimulus: cont=1, period 8.
  - Required: valid every 32 cycles with period=8 and no gap cycles.
  - Stimulus: drop cont.
  - Required: the next completion returns to IDLE.
- Start while busy:
  - Stimulus: start pulses during MEASURE.
  - Required: ignored; the result is unchanged.
- Reset mid-measurement:
  - Stimulus: reset during MEASURE.
  - Required: all outputs 0 on the next cycle.
  - Required: a new start measures correctly, and the first rise after reset is ignored if `sig_in` was high.
